timer_dev: RTL and testbench

Programmable down-counting timer peripheral sitting directly behind the system bridge on device port 0 (CPU window 0x0000_7F00–0x0000_7F0B). It exposes three word registers through the bridge's device-side bus (2-bit word address, byte enables, write data, write enable) and returns read data combinationally. It raises IntReq, which the bridge forwards to the CPU as HWInt[2]. The FSM supports one-shot mode and auto-reload mode.

---
 rtl/timer_dev.sv | 203 ++++++++++++++++++++
 tb/tb_timer_dev.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: programmable down-counting timer with one-shot and auto-reload modes.
// Latency: zero-cycle combinational read; CPU writes land on the same edge; IntReq is registered (IM & PEND).
// Backpressure: none; the bridge strobes WE for one cycle and every access completes immediately.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   Addr    word address: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=unused
//   BE      byte enables for writes, BE[i] gates byte lane i
//   WD      write data
//   WE      single-cycle write strobe
//   RD      combinational read data for Addr
//   IntReq  registered interrupt request (IM & PEND)
//
// CTRL layout: [0] EN, [2:1] MODE (01 = auto-reload, all others one-shot),
// [3] IM, [4] PEND (read-only), [31:5] zero.

module timer_dev (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Addr,
  input  logic [3:0]  BE,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        IntReq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic        r_pend;
  logic        r_intreq;
  logic [31:0] r_preset;
  logic [31:0] r_count;

  logic        w_ctrl_wr;
  logic        w_ctrl_lo_wr;
  logic        w_preset_wr;
  logic        w_auto;
  logic        w_cnt_zero;
  logic        w_en_nxt;

  // FSM output strobes
  logic        w_load;
  logic        w_dec;
  logic        w_int_set;
  logic        w_int_clr;
  logic        w_hw_clr_en;

  assign w_ctrl_wr    = WE && (Addr == 2'd0);
  assign w_ctrl_lo_wr = w_ctrl_wr && BE[0];
  assign w_preset_wr  = WE && (Addr == 2'd1);
  assign w_auto       = (r_mode == 2'b01);
  assign w_cnt_zero   = (r_count == 32'd0);

  // A CPU write to EN beats the hardware clear when both land on one edge.
  assign w_en_nxt = w_ctrl_lo_wr ? WD[0] : (w_hw_clr_en ? 1'b0 : r_en);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  // IDLE reacts to the EN value being written on this edge, so an enable
  // write moves straight to LOAD; every other state looks at the
  // pre-edge register values.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_en_nxt) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_CNT;
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_INT;
        end
      end
      S_INT:   w_state_nxt = w_auto ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_int_set   = 1'b0;
    w_int_clr   = 1'b0;
    w_hw_clr_en = 1'b0;
    case (r_state)
      S_LOAD: w_load = 1'b1;
      S_CNT: begin
        if (r_en) begin
          if (w_cnt_zero) begin
            w_int_set = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      S_INT: begin
        if (w_auto) begin
          w_int_clr = 1'b1;
        end else begin
          w_hw_clr_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- CTRL fields ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_mode <= 2'b00;
      r_im   <= 1'b0;
    end else begin
      r_en <= w_en_nxt;
      if (w_ctrl_lo_wr) begin
        r_mode <= WD[2:1];
        r_im   <= WD[3];
      end
    end
  end

  // PEND: a set on INT entry wins over any clear on the same edge so an
  // expiry coinciding with a CTRL write is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else if (w_int_set) begin
      r_pend <= 1'b1;
    end else if (w_int_clr || w_ctrl_wr) begin
      r_pend <= 1'b0;
    end
  end

  // ---------------- PRESET (byte-lane writes) ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preset <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_preset_wr && BE[i]) begin
          r_preset[8*i +: 8] <= WD[8*i +: 8];
        end
      end
    end
  end

  // ---------------- COUNT ----------------
  // Never wraps: a zero count leaves CNT for INT instead of decrementing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 32'd0;
    end else if (w_load) begin
      r_count <= r_preset;
    end else if (w_dec) begin
      r_count <= r_count - 32'd1;
    end
  end

  // ---------------- interrupt ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_intreq <= 1'b0;
    end else begin
      r_intreq <= r_im & r_pend;
    end
  end

  assign IntReq = r_intreq;

  // ---------------- read mux ----------------
  always_comb begin
    RD = 32'd0;
    case (Addr)
      2'd0:    RD = {27'd0, r_pend, r_im, r_mode, r_en};
      2'd1:    RD = r_preset;
      2'd2:    RD = r_count;
      default: RD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev.
// Stimulus pushes expected RD/IntReq values tagged with a cycle number; a negedge monitor pops and compares.
// Expected values come from closed-form period arithmetic over cycles since the enable write.

module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  Addr;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        IntReq;

  timer_dev dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Addr   (Addr),
    .BE     (BE),
    .WD     (WD),
    .WE     (WE),
    .RD     (RD),
    .IntReq (IntReq)
  );

  always #5 clk = ~clk;

  // number of rising edges seen so far
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // scoreboard queues (parallel)
  int          q_cyc[$];
  bit          q_irq[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  int n_tests = 0;
  int n_fail  = 0;

  // monitor temporaries
  int          m_c;
  bit          m_i;
  logic [31:0] m_e;
  string       m_nm;

  task automatic exp_rd(input string name, input logic [31:0] v);
    q_cyc.push_back(cyc_n);
    q_irq.push_back(1'b0);
    q_exp.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic exp_irq(input string name, input logic v);
    q_cyc.push_back(cyc_n);
    q_irq.push_back(1'b1);
    q_exp.push_back({31'd0, v});
    q_name.push_back(name);
  endtask

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc_n) begin
      m_c  = q_cyc.pop_front();
      m_i  = q_irq.pop_front();
      m_e  = q_exp.pop_front();
      m_nm = q_name.pop_front();
      n_tests++;
      if (m_c != cyc_n) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d reached monitor late at cycle %0d", m_nm, m_c, cyc_n);
      end else if (m_i) begin
        if (IntReq !== m_e[0]) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: IntReq=%b expected %b", m_nm, cyc_n, IntReq, m_e[0]);
        end
      end else if (RD !== m_e) begin
        n_fail++;
        $display("FAIL %s @cycle %0d: RD=0x%08h expected 0x%08h (Addr=%0d)", m_nm, cyc_n, RD, m_e, Addr);
      end
    end
  end

  // ---------------- reference model ----------------
  // t = number of edges since the edge that wrote EN=1 (t=0 is right after it).
  // One period of N+3 cycles: count N..0 over t=1..N+1, INT at u=N+1, reload at u=N+2.
  int         mN;
  bit         mAuto;
  bit         mIm;
  logic [1:0] mMode;

  function automatic logic [31:0] m_count(input int t);
    int u;
    if (t < 1) return 32'd0;
    u = t - 1;
    if (mAuto) u = u % (mN + 3);
    if (u <= mN) return 32'(mN - u);
    return 32'd0;
  endfunction

  function automatic bit m_pend(input int t);
    int u;
    if (t < 1) return 1'b0;
    u = t - 1;
    if (mAuto) return ((u % (mN + 3)) == mN + 1);
    return (u >= mN + 1);
  endfunction

  function automatic bit m_en(input int t);
    if (mAuto) return 1'b1;
    return (t < mN + 3);
  endfunction

  function automatic bit m_irq(input int t);
    if (t < 1) return 1'b0;
    return mIm && m_pend(t - 1);
  endfunction

  function automatic logic [31:0] m_ctrl(input int t);
    return {27'd0, m_pend(t), mIm, mMode, m_en(t)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    Addr = a;
    BE   = be;
    WD   = d;
    WE   = 1'b1;
  endtask

  // Assumes we are just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    WE    = 1'b0;
    Addr  = 2'd0; exp_rd("rst_ctrl", 32'd0);  exp_irq("rst_irq", 1'b0); step();
    Addr  = 2'd2; exp_rd("rst_count", 32'd0); exp_irq("rst_irq", 1'b0); step();
    Addr  = 2'd1; exp_rd("rst_preset", 32'd0); step();
    rst_n = 1'b1;
  endtask

  task automatic run_scenario(input int n, input logic [1:0] mode, input bit im);
    int T;
    int a;
    mN = n; mMode = mode; mAuto = (mode == 2'b01); mIm = im;
    do_reset();
    wr(2'd1, 4'hF, 32'(n));                       exp_rd("preset_before", 32'd0); step();
    wr(2'd0, 4'h1, {28'd0, im, mode, 1'b1});      exp_rd("ctrl_before", 32'd0);   step();
    T = mAuto ? 4 * (n + 3) + 1 : n + 6;
    for (int t = 0; t <= T; t++) begin
      a = $urandom_range(0, 3);
      case (a)
        0, 1: begin Addr = 2'd2; exp_rd("count", m_count(t)); end
        2:    begin Addr = 2'd0; exp_rd("ctrl", m_ctrl(t)); end
        default: begin Addr = 2'd1; exp_rd("preset", 32'(n)); end
      endcase
      exp_irq("irq", m_irq(t));
      step();
    end
    if (!mAuto) begin
      // IntReq holds until a CTRL write, then falls one edge later
      wr(2'd0, 4'hF, 32'd0);
      exp_rd("ctrl_done", m_ctrl(T + 1)); exp_irq("irq_held", m_irq(T + 1)); step();
      exp_rd("ctrl_cleared", 32'd0);      exp_irq("irq_after_wr", im);        step();
      exp_irq("irq_fall", 1'b0); step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; Addr = 2'd0; BE = 4'h0; WD = 32'd0; WE = 1'b0;
    @(posedge clk); #1;

    // test-plan scenarios: one-shot, auto-reload, masked
    run_scenario(5, 2'b00, 1'b1);
    run_scenario(3, 2'b01, 1'b1);
    run_scenario(4, 2'b00, 1'b0);
    run_scenario(2, 2'b01, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_scenario(int'($urandom_range(0, 8)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // byte lanes, partial CTRL write, Addr=3
    do_reset();
    wr(2'd1, 4'b0101, 32'hAABBCCDD); exp_rd("preset_pre_be", 32'd0); step();
    Addr = 2'd1; exp_rd("preset_be", 32'h00BB00DD); step();
    wr(2'd0, 4'b1110, 32'h0000000F); step();
    Addr = 2'd0; exp_rd("ctrl_be0_off", 32'd0); exp_irq("irq_idle", 1'b0); step();
    wr(2'd3, 4'hF, 32'h12345678); exp_rd("addr3", 32'd0); step();
    Addr = 2'd3; exp_rd("addr3_after", 32'd0); step();

    // enable drop at COUNT=7 of PRESET=20
    mN = 20; mMode = 2'b00; mAuto = 1'b0; mIm = 1'b1;
    do_reset();
    wr(2'd1, 4'hF, 32'd20); step();
    wr(2'd0, 4'h1, 32'h9);  step();
    for (int t = 0; t <= 13; t++) begin
      Addr = 2'd2; exp_rd("drop_count", m_count(t)); exp_irq("drop_irq", m_irq(t)); step();
    end
    wr(2'd0, 4'h1, 32'h8); exp_rd("drop_ctrl_pre", 32'h9); step();   // lands while COUNT=7
    Addr = 2'd2; exp_rd("drop_frozen", 32'd6); step();
    Addr = 2'd0; exp_rd("drop_ctrl", 32'h8); step();
    wr(2'd2, 4'hF, 32'hFFFFFFFF); exp_rd("count_wr", 32'd6); step();
    for (int k = 0; k < 5; k++) begin
      Addr = 2'd2; exp_rd("drop_hold", 32'd6); exp_irq("drop_no_irq", 1'b0); step();
    end
    wr(2'd0, 4'h1, 32'h9); exp_rd("reen_ctrl_pre", 32'h8); step();
    Addr = 2'd2; exp_rd("reen_load", 32'd6);  step();
    Addr = 2'd2; exp_rd("reen_count", 32'd20); step();
    Addr = 2'd2; exp_rd("reen_dec", 32'd19);  step();

    // PRESET=0 with CTRL writes colliding on INT entry and on one-shot exit
    do_reset();
    wr(2'd1, 4'hF, 32'd0); step();
    wr(2'd0, 4'h1, 32'h9); step();
    Addr = 2'd2; exp_rd("z_count", 32'd0); exp_irq("z_irq0", 1'b0); step();
    wr(2'd0, 4'h1, 32'h9); exp_rd("z_ctrl1", 32'h09); step();
    wr(2'd0, 4'h1, 32'h9); exp_rd("z_int_entry_pend", 32'h19); step();
    Addr = 2'd0; exp_rd("z_exit_en_wins", 32'h09); exp_irq("z_irq_hi", 1'b1); step();
    Addr = 2'd2; exp_rd("z_idle_count", 32'd0);    exp_irq("z_irq_lo", 1'b0); step();
    Addr = 2'd0; exp_rd("z_load", 32'h09); step();
    Addr = 2'd0; exp_rd("z_int2", 32'h19); step();
    Addr = 2'd0; exp_rd("z_oneshot_end", 32'h18); exp_irq("z_irq2", 1'b1); step();

    // async reset while IntReq is high (auto-reload, PRESET=3)
    mN = 3; mMode = 2'b01; mAuto = 1'b1; mIm = 1'b1;
    do_reset();
    wr(2'd1, 4'hF, 32'd3); step();
    wr(2'd0, 4'h1, 32'hB); step();
    for (int t = 0; t <= 5; t++) begin
      Addr = 2'd2; exp_rd("mr_count", m_count(t)); exp_irq("mr_irq", m_irq(t)); step();
    end
    rst_n = 1'b0;   // IntReq would read 1 in this cycle
    Addr = 2'd0; exp_rd("mr_ctrl", 32'd0); exp_irq("mr_irq_rst", 1'b0); step();
    Addr = 2'd2; exp_rd("mr_count_rst", 32'd0); step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      Addr = (k % 2 == 0) ? 2'd2 : 2'd0;
      exp_rd("mr_stays_idle", 32'd0); exp_irq("mr_no_irq", 1'b0); step();
    end

    step(); step();
    if (q_cyc.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q_cyc.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
